// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: slow input plus the period/high-time measurement results.
interface clk_period_meter_if #(parameter int CNT_W = 28);
  logic sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic valid;
  logic timeout;
  logic locked;
  modport master (input sig_in, output period, high_time, valid, timeout, locked);
  modport slave (output sig_in, input period, high_time, valid, timeout, locked);
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow async signal in clk_in cycles.
module clk_period_meter #(
  parameter int CNT_W = 28,
  parameter int SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT = 28'd100_000_000
) (
  input logic clk_in,
  input logic reset,
  clk_period_meter_if.master m
);
  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic p, s, rise, fall;
  logic [CNT_W-1:0] cnt, cnt_n, period, period_n, high_time, high_n, hi_lat, lat_n;
  logic valid, valid_n, timeout, timeout_n, hi_seen, seen_n;
  assign s = sync[SYNC_STAGES-1];
  assign rise = s & ~p;
  assign fall = ~s & p;
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync <= '0;
      p <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      period <= '0;
      high_time <= '0;
      hi_lat <= '0;
      hi_seen <= 1'b0;
      valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], m.sig_in};
      p <= s;
      state <= state_n;
      cnt <= cnt_n;
      period <= period_n;
      high_time <= high_n;
      hi_lat <= lat_n;
      hi_seen <= seen_n;
      valid <= valid_n;
      timeout <= timeout_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    period_n = period;
    high_n = high_time;
    lat_n = hi_lat;
    seen_n = hi_seen;
    valid_n = 1'b0;
    timeout_n = timeout;
    if (state == IDLE) begin
      cnt_n = rise ? CNT_W'(1) : '0;
      state_n = rise ? ARMED : IDLE;
      seen_n = 1'b0;
    end else if (rise) begin
      // a period with no fall (glitch-merged) reports the whole period as high
      period_n = cnt;
      high_n = (state == ARMED) ? high_time : (hi_seen ? hi_lat : cnt);
      cnt_n = CNT_W'(1);
      valid_n = 1'b1;
      timeout_n = 1'b0;
      seen_n = 1'b0;
      state_n = MEASURE;
    end else if (cnt == TIMEOUT) begin
      timeout_n = 1'b1;
      period_n = '0;
      high_n = '0;
      cnt_n = '0;
      state_n = IDLE;
    end else begin
      cnt_n = cnt + 1'b1;
      high_n = (fall && state == ARMED) ? cnt : high_time;
      lat_n = (fall && state == MEASURE) ? cnt : hi_lat;
      seen_n = hi_seen | (fall && state == MEASURE);
    end
  end
  assign m.period = period;
  assign m.high_time = high_time;
  assign m.valid = valid;
  assign m.timeout = timeout;
  assign m.locked = (state == MEASURE);
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed scoreboard bench for clk_period_meter.
module tb_clk_period_meter;
  localparam int CNT_W = 28;
  localparam int TMO = 1000;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int last_rise = 0;
  int last_high = 0;
  bit armed = 1'b0;
  logic [2*CNT_W-1:0] q[$];
  logic [2*CNT_W-1:0] exp_v;
  clk_period_meter_if #(.CNT_W(CNT_W)) bus ();
  clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(28'(TMO))) dut (
    .clk_in(clk_in),
    .reset(reset),
    .m(bus)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  always @(negedge clk_in) begin
    if (bus.valid === 1'b1) begin
      chk("valid_expected", CNT_W'(q.size() > 0), 1);
      if (q.size() > 0) begin
        exp_v = q.pop_front();
        chk("period", bus.period, exp_v[2*CNT_W-1:CNT_W]);
        chk("high_time", bus.high_time, exp_v[CNT_W-1:0]);
        chk("locked_at_valid", CNT_W'(bus.locked), 1);
        chk("timeout_at_valid", CNT_W'(bus.timeout), 0);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk_in);
      cyc_n++;
    end
  endtask
  task automatic rise_edge();
    bus.sig_in = 1'b1;
    if (armed) q.push_back({CNT_W'(cyc_n - last_rise), CNT_W'(last_high)});
    armed = 1'b1;
    last_rise = cyc_n;
  endtask
  task automatic fall_edge();
    bus.sig_in = 1'b0;
    last_high = cyc_n - last_rise;
  endtask
  task automatic wave(input int per, input int hi, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      rise_edge();
      cyc(hi);
      fall_edge();
      cyc(per - hi);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_period"}, bus.period, 0);
    chk({tag, "_high"}, bus.high_time, 0);
    chk({tag, "_valid"}, CNT_W'(bus.valid), 0);
    chk({tag, "_locked"}, CNT_W'(bus.locked), 0);
  endtask
  initial begin
    bus.sig_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      bus.sig_in = ~bus.sig_in;
      chk_idle("reset");
      chk("reset_timeout", CNT_W'(bus.timeout), 0);
    end
    bus.sig_in = 1'b0;
    reset = 1'b0;
    cyc(2);
    wave(10, 4, 5);
    chk("locked_sq10", CNT_W'(bus.locked), 1);
    wave(20, 10, 4);
    cyc(last_rise + TMO + 2 - cyc_n);
    chk("timeout_early", CNT_W'(bus.timeout), 0);
    cyc(1);
    chk("timeout_set", CNT_W'(bus.timeout), 1);
    chk_idle("timeout");
    armed = 1'b0;
    rise_edge();
    cyc(4);
    chk("timeout_sticky", CNT_W'(bus.timeout), 1);
    chk("unlocked_armed", CNT_W'(bus.locked), 0);
    fall_edge();
    cyc(6);
    wave(10, 4, 3);
    chk("timeout_cleared", CNT_W'(bus.timeout), 0);
    chk("relocked", CNT_W'(bus.locked), 1);
    rise_edge();
    cyc(4);
    fall_edge();
    cyc(TMO - 4);
    rise_edge();
    cyc(4);
    fall_edge();
    cyc(6);
    chk("boundary_no_timeout", CNT_W'(bus.timeout), 0);
    chk("boundary_locked", CNT_W'(bus.locked), 1);
    rise_edge();
    cyc(4);
    fall_edge();
    cyc(2);
    reset = 1'b1;
    armed = 1'b0;
    cyc(2);
    chk_idle("midreset");
    reset = 1'b0;
    cyc(3);
    chk_idle("post_reset");
    wave(10, 4, 3);
    cyc(10);
    chk("queue_drained", CNT_W'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
